bcd2bin_seq: RTL

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

---
 rtl/bcd2bin_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit signed BCD to binary converter.
// Reverse double-dabble, one bit per clock, with digit and overflow flags.
module bcd2bin_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [12:0] bcd_in,
   output logic        busy,
   output logic        done,
   output logic [8:0]  bin_out,
   output logic        ovf,
   output logic        err_digit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] work;
   logic [11:0] work_sh;
   logic [11:0] work_adj;
   logic [7:0]  shreg;
   logic [7:0]  shreg_sh;
   logic [2:0]  cnt;
   logic        sign;
   logic        bad_digit;
   logic        last;
   logic        take;

   assign take = (state == IDLE) && start;
   assign last = (cnt == 3'd7);

   assign bad_digit = (bcd_in[11:8] > 4'd9) ||
                      (bcd_in[7:4]  > 4'd9) ||
                      (bcd_in[3:0]  > 4'd9);

   assign work_sh  = {1'b0, work[11:1]};
   assign shreg_sh = {work[0], shreg[7:1]};

   // Digits of 8+ after a right shift came from a carried-in 10, so drop 3.
   always_comb begin
      work_adj = work_sh;
      for (int i = 0; i < 3; i++) begin
         if (work_sh[i*4 +: 4] >= 4'd8) begin
            work_adj[i*4 +: 4] = work_sh[i*4 +: 4] - 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = bad_digit ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work      <= '0;
         shreg     <= '0;
         cnt       <= '0;
         sign      <= 1'b0;
         bin_out   <= '0;
         ovf       <= 1'b0;
         err_digit <= 1'b0;
      end else if (take) begin
         work  <= bcd_in[11:0];
         sign  <= bcd_in[12];
         shreg <= '0;
         cnt   <= '0;
         if (bad_digit) begin
            bin_out   <= {bcd_in[12], 8'h00};
            ovf       <= 1'b0;
            err_digit <= 1'b1;
         end
      end else if (state == SHIFT) begin
         work  <= work_adj;
         shreg <= shreg_sh;
         cnt   <= cnt + 3'd1;
         // Residual work digits hold value / 256, so nonzero means overflow.
         if (last) begin
            bin_out   <= {sign, shreg_sh};
            ovf       <= |work_adj;
            err_digit <= 1'b0;
         end
      end
   end

endmodule
